// File: rtl/write_back_arbiter_if.sv
// Write-back port bundle: ALU result stream, load-return stream, flush,
// and the register-file write port with its status outputs.
interface write_back_arbiter_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
);
    logic                  aluValid;
    logic [ADDR_WIDTH-1:0] aluDest;
    logic [DATA_WIDTH-1:0] aluResult;
    logic                  aluReady;
    logic                  loadValid;
    logic [ADDR_WIDTH-1:0] loadDest;
    logic [DATA_WIDTH-1:0] readData;
    logic                  flush;
    logic                  regWrite;
    logic [ADDR_WIDTH-1:0] writeReg;
    logic [DATA_WIDTH-1:0] writeData;
    logic                  memToReg;
    logic [3:0]            pending;
    logic [15:0]           conflictCount;

    modport master (
        output aluValid, aluDest, aluResult, loadValid, loadDest, readData, flush,
        input  aluReady, regWrite, writeReg, writeData, memToReg, pending, conflictCount
    );

    modport slave (
        input  aluValid, aluDest, aluResult, loadValid, loadDest, readData, flush,
        output aluReady, regWrite, writeReg, writeData, memToReg, pending, conflictCount
    );
endinterface

// File: rtl/write_back_arbiter.sv
// Single register-file write port shared by load returns (always win) and
// ALU results (buffered in order when they lose a cycle).
module write_back_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int DEPTH      = 2
) (
    input  logic                clk,
    input  logic                rstN,
    write_back_arbiter_if.slave wb
);
    localparam int         PTR_W     = $clog2(DEPTH);
    localparam logic [3:0] DEPTH_CNT = 4'(DEPTH);

    localparam logic [1:0] GNT_IDLE = 2'd0;
    localparam logic [1:0] GNT_LOAD = 2'd1;
    localparam logic [1:0] GNT_BUF  = 2'd2;
    localparam logic [1:0] GNT_ALU  = 2'd3;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    logic [DATA_WIDTH-1:0] fifo_data [DEPTH];
    logic [ADDR_WIDTH-1:0] fifo_dest [DEPTH];
    logic [PTR_W-1:0]      head;
    logic [PTR_W-1:0]      tail;
    logic [3:0]            count;
    logic [3:0]            count_next;
    logic [15:0]           conflict_cnt;
    logic                  ready;

    logic                  accept_p0;
    logic                  enq_p0;
    logic                  deq_p0;
    logic                  conflict_p0;
    logic [1:0]            grant_p0;
    logic [ADDR_WIDTH-1:0] sel_dest_p0;
    logic [DATA_WIDTH-1:0] sel_data_p0;

    logic                  vld_p1;
    logic                  mem_sel_p1;
    logic [ADDR_WIDTH-1:0] dest_p1;
    logic [DATA_WIDTH-1:0] data_p1;

    // Ready depends only on registered occupancy, never on this cycle's valids.
    assign ready     = (count < DEPTH_CNT);
    assign accept_p0 = wb.aluValid && ready;

    // Stage p0: grant selection and buffer bookkeeping
    always_comb begin
        grant_p0    = GNT_IDLE;
        sel_dest_p0 = wb.aluDest;
        sel_data_p0 = wb.aluResult;
        if (wb.loadValid) begin
            grant_p0 = GNT_LOAD;
        end else if (wb.flush) begin
            grant_p0 = GNT_IDLE;
        end else if (count != 4'd0) begin
            grant_p0 = GNT_BUF;
        end else if (accept_p0) begin
            grant_p0 = GNT_ALU;
        end

        case (grant_p0)
            GNT_LOAD: begin
                sel_dest_p0 = wb.loadDest;
                sel_data_p0 = wb.readData;
            end
            GNT_BUF: begin
                sel_dest_p0 = fifo_dest[head];
                sel_data_p0 = fifo_data[head];
            end
            default: ;
        endcase

        enq_p0      = accept_p0 && !wb.flush && (wb.loadValid || (count != 4'd0));
        deq_p0      = (grant_p0 == GNT_BUF);
        conflict_p0 = wb.loadValid && accept_p0 && !wb.flush;
        count_next  = count + {3'b000, enq_p0} - {3'b000, deq_p0};
    end

    always_ff @(posedge clk) begin
        if (enq_p0) begin
            fifo_dest[tail] <= wb.aluDest;
            fifo_data[tail] <= wb.aluResult;
        end
    end

    // Stage p1: registered write port
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            count        <= 4'd0;
            head         <= '0;
            tail         <= '0;
            conflict_cnt <= 16'd0;
            vld_p1       <= 1'b0;
            mem_sel_p1   <= 1'b0;
            dest_p1      <= '0;
            data_p1      <= '0;
        end else begin
            if (wb.flush) begin
                count <= 4'd0;
                head  <= '0;
                tail  <= '0;
            end else begin
                count <= count_next;
                if (enq_p0) tail <= tail + PTR_W'(1);
                if (deq_p0) head <= head + PTR_W'(1);
            end

            if (conflict_p0) conflict_cnt <= sat_inc16(conflict_cnt);

            if (grant_p0 == GNT_IDLE) begin
                vld_p1     <= 1'b0;
                mem_sel_p1 <= 1'b0;
            end else begin
                // Register 0 still consumes the slot but must not be written.
                vld_p1     <= (sel_dest_p0 != '0);
                mem_sel_p1 <= (grant_p0 == GNT_LOAD);
                dest_p1    <= sel_dest_p0;
                data_p1    <= sel_data_p0;
            end
        end
    end

    assign wb.aluReady      = ready;
    assign wb.regWrite      = vld_p1;
    assign wb.memToReg      = mem_sel_p1;
    assign wb.writeReg      = dest_p1;
    assign wb.writeData     = data_p1;
    assign wb.pending       = count;
    assign wb.conflictCount = conflict_cnt;
endmodule

// File: tb/tb_write_back_arbiter.sv
// Directed table-driven bench for write_back_arbiter (DEPTH=2), plus a
// hand-written asynchronous reset sequence.
module tb_write_back_arbiter;
    logic clk = 1'b0;
    logic rstN = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    write_back_arbiter_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) bus ();

    write_back_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .DEPTH(2)) dut (
        .clk  (clk),
        .rstN (rstN),
        .wb   (bus.slave)
    );

    typedef struct {
        logic        lv;
        logic [4:0]  ld;
        logic [31:0] rd;
        logic        av;
        logic [4:0]  ad;
        logic [31:0] ar;
        logic        fl;
        logic        e_rw;
        logic [4:0]  e_wr;
        logic [31:0] e_wd;
        logic        e_mr;
        logic [3:0]  e_pend;
        logic        e_rdy;
        logic [15:0] e_cc;
    } vec_t;

    localparam int NV = 26;
    vec_t vecs [NV];

    function automatic vec_t mk(input logic lv, input logic [4:0] ld, input logic [31:0] rd,
                                input logic av, input logic [4:0] ad, input logic [31:0] ar,
                                input logic fl, input logic e_rw, input logic [4:0] e_wr,
                                input logic [31:0] e_wd, input logic e_mr, input logic [3:0] e_pend,
                                input logic e_rdy, input logic [15:0] e_cc);
        vec_t v;
        v.lv = lv; v.ld = ld; v.rd = rd; v.av = av; v.ad = ad; v.ar = ar; v.fl = fl;
        v.e_rw = e_rw; v.e_wr = e_wr; v.e_wd = e_wd; v.e_mr = e_mr;
        v.e_pend = e_pend; v.e_rdy = e_rdy; v.e_cc = e_cc;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic lv, input logic [4:0] ld, input logic [31:0] rd,
                         input logic av, input logic [4:0] ad, input logic [31:0] ar,
                         input logic fl);
        bus.loadValid = lv; bus.loadDest = ld; bus.readData = rd;
        bus.aluValid = av; bus.aluDest = ad; bus.aluResult = ar; bus.flush = fl;
    endtask

    task automatic check_outputs(input string tag, input logic rw, input logic [4:0] wr,
                                 input logic [31:0] wd, input logic mr, input logic [3:0] pend,
                                 input logic rdy, input logic [15:0] cc);
        check({tag, ".regWrite"},      32'(bus.regWrite),      32'(rw));
        check({tag, ".writeReg"},      32'(bus.writeReg),      32'(wr));
        check({tag, ".writeData"},     bus.writeData,          wd);
        check({tag, ".memToReg"},      32'(bus.memToReg),      32'(mr));
        check({tag, ".pending"},       32'(bus.pending),       32'(pend));
        check({tag, ".aluReady"},      32'(bus.aluReady),      32'(rdy));
        check({tag, ".conflictCount"}, 32'(bus.conflictCount), 32'(cc));
    endtask

    initial begin
        //              lv ld  rd           av ad  ar           fl rw wr  wd           mr pd rdy cc
        vecs[0]  = mk(0, 0,  0,           0, 0,  0,           0, 0, 0,  32'h0,      0, 0, 1, 0); // idle after reset
        vecs[1]  = mk(0, 0,  0,           1, 3,  32'h1234,    0, 1, 3,  32'h1234,   0, 0, 1, 0); // ALU only
        vecs[2]  = mk(0, 0,  0,           0, 0,  0,           0, 0, 3,  32'h1234,   0, 0, 1, 0); // idle holds data
        vecs[3]  = mk(1, 4,  32'hAAAA,    1, 5,  32'h5555,    0, 1, 4,  32'hAAAA,   1, 1, 1, 1); // collision
        vecs[4]  = mk(0, 0,  0,           0, 0,  0,           0, 1, 5,  32'h5555,   0, 0, 1, 1); // buffered ALU drains
        vecs[5]  = mk(1, 10, 32'h100,     1, 11, 32'h200,     0, 1, 10, 32'h100,    1, 1, 1, 2); // fill buffer
        vecs[6]  = mk(1, 12, 32'h300,     1, 13, 32'h400,     0, 1, 12, 32'h300,    1, 2, 0, 3);
        vecs[7]  = mk(1, 14, 32'h500,     1, 15, 32'h600,     0, 1, 14, 32'h500,    1, 2, 0, 3); // full, load still writes
        vecs[8]  = mk(1, 16, 32'h700,     1, 15, 32'h600,     0, 1, 16, 32'h700,    1, 2, 0, 3);
        vecs[9]  = mk(0, 0,  0,           1, 15, 32'h600,     0, 1, 11, 32'h200,    0, 1, 1, 3); // head drains
        vecs[10] = mk(0, 0,  0,           1, 15, 32'h600,     0, 1, 13, 32'h400,    0, 1, 1, 3); // enq+deq same cycle
        vecs[11] = mk(0, 0,  0,           0, 0,  0,           0, 1, 15, 32'h600,    0, 0, 1, 3);
        vecs[12] = mk(0, 0,  0,           0, 0,  0,           0, 0, 15, 32'h600,    0, 0, 1, 3);
        vecs[13] = mk(0, 0,  0,           1, 0,  32'hDEAD,    0, 0, 0,  32'hDEAD,   0, 0, 1, 3); // r0 suppressed
        vecs[14] = mk(0, 0,  0,           1, 7,  32'h77,      0, 1, 7,  32'h77,     0, 0, 1, 3); // next beat, no gap
        vecs[15] = mk(0, 0,  0,           0, 0,  0,           0, 0, 7,  32'h77,     0, 0, 1, 3);
        vecs[16] = mk(1, 1,  32'h11,      1, 2,  32'h22,      0, 1, 1,  32'h11,     1, 1, 1, 4); // build pending=2
        vecs[17] = mk(1, 6,  32'h66,      1, 8,  32'h88,      0, 1, 6,  32'h66,     1, 2, 0, 5);
        vecs[18] = mk(1, 9,  32'h99,      1, 20, 32'hBB,      1, 1, 9,  32'h99,     1, 0, 1, 5); // flush + load
        vecs[19] = mk(0, 0,  0,           0, 0,  0,           0, 0, 9,  32'h99,     0, 0, 1, 5); // flushed entries gone
        vecs[20] = mk(0, 0,  0,           0, 0,  0,           0, 0, 9,  32'h99,     0, 0, 1, 5);
        vecs[21] = mk(0, 0,  0,           1, 21, 32'h1,       1, 0, 9,  32'h99,     0, 0, 1, 5); // live beat dropped
        vecs[22] = mk(0, 0,  0,           0, 0,  0,           0, 0, 9,  32'h99,     0, 0, 1, 5);
        vecs[23] = mk(1, 3,  32'h33,      1, 4,  32'h44,      0, 1, 3,  32'h33,     1, 1, 1, 6);
        vecs[24] = mk(0, 0,  0,           0, 0,  0,           1, 0, 3,  32'h33,     0, 0, 1, 6); // flush head, no load
        vecs[25] = mk(0, 0,  0,           0, 0,  0,           0, 0, 3,  32'h33,     0, 0, 1, 6);

        drive(0, 0, 0, 1, 9, 32'hFFFF, 0); // ignored while in reset
        repeat (3) @(posedge clk);
        #1;
        check_outputs("reset", 0, 0, 32'h0, 0, 0, 1, 0);
        rstN = 1'b1;

        for (int i = 0; i < NV; i++) begin
            drive(vecs[i].lv, vecs[i].ld, vecs[i].rd, vecs[i].av, vecs[i].ad, vecs[i].ar, vecs[i].fl);
            @(posedge clk);
            #1;
            check_outputs($sformatf("vec%0d", i), vecs[i].e_rw, vecs[i].e_wr, vecs[i].e_wd,
                          vecs[i].e_mr, vecs[i].e_pend, vecs[i].e_rdy, vecs[i].e_cc);
        end

        // Reset mid-operation with two buffered entries
        drive(1, 17, 32'h1700, 1, 18, 32'h1800, 0);
        @(posedge clk); #1;
        drive(1, 19, 32'h1900, 1, 20, 32'h2000, 0);
        @(posedge clk); #1;
        check_outputs("pre_rst", 1, 19, 32'h1900, 1, 2, 0, 8);
        #2 rstN = 1'b0;
        #1;
        check_outputs("async_rst", 0, 0, 32'h0, 0, 0, 1, 0);
        drive(1, 21, 32'h2100, 1, 22, 32'h2200, 0);
        @(posedge clk); #1;
        check_outputs("held_rst", 0, 0, 32'h0, 0, 0, 1, 0);
        drive(0, 0, 0, 0, 0, 0, 0);
        rstN = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check_outputs($sformatf("post_rst%0d", i), 0, 0, 32'h0, 0, 0, 1, 0);
        end
        drive(0, 0, 0, 1, 22, 32'h2222, 0);
        @(posedge clk); #1;
        check_outputs("post_rst_alu", 1, 22, 32'h2222, 0, 0, 1, 0);
        drive(0, 0, 0, 0, 0, 0, 0);
        @(posedge clk); #1;
        check_outputs("post_rst_idle", 0, 22, 32'h2222, 0, 0, 1, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/write_back_arbiter.md
# write_back_arbiter

Arbitrates the single register-file write port between the ALU result stream and the load-return stream. Load returns can never be stalled, so they always win. ALU results that lose a cycle are held in a small in-order buffer and drained when the port is free. Sits between the execute/memory stages and the register file, and drives the same memToReg select and writeData path used by the write-back mux.

## Interface
Parameters:
- DATA_WIDTH, 32, width of result and write data
- ADDR_WIDTH, 5, register address width
- DEPTH, 2, ALU buffer entries; power of two, 2..8

Ports:
- clk  in  1  system clock; all state changes on rising edge
- rstN  in  1  asynchronous, active-low reset
- aluValid  in  1  ALU result present this cycle
- aluDest  in  ADDR_WIDTH  ALU destination register
- aluResult  in  DATA_WIDTH  ALU result
- aluReady  out  1  ALU stream may present a result; an ALU beat is accepted when aluValid && aluReady
- loadValid  in  1  load data returning this cycle; always accepted
- loadDest  in  ADDR_WIDTH  load destination register
- readData  in  DATA_WIDTH  load data
- flush  in  1  synchronous; discards all buffered ALU entries
- regWrite  out  1  register-file write enable
- writeReg  out  ADDR_WIDTH  register-file write address
- writeData  out  DATA_WIDTH  register-file write data
- memToReg  out  1  1 = current write sourced from load, 0 = from ALU
- pending  out  4  buffered ALU entry count, 0..DEPTH
- conflictCount  out  16  saturating count of accepted ALU beats forced into the buffer by a load

## Operation
- One write is granted per cycle. Priority order: load, then buffer head (oldest), then live accepted ALU beat.
- aluReady = (pending < DEPTH), derived from registered count only, with no combinational path from aluValid or loadValid.
- An accepted ALU beat that is not granted this cycle enqueues at the buffer tail. This happens when a load is valid or the buffer is non-empty.
- An accepted beat and a dequeue in the same cycle leave pending unchanged. Head/tail pointers wrap modulo DEPTH.
- ALU results are written in acceptance order. Order between the load and ALU streams is the issuer's responsibility.
- A granted write with destination 0 drives regWrite=0 but still consumes the grant and the buffer entry.
- flush=1:
  - pending becomes 0 next cycle.
  - Any live ALU beat is dropped.
  - A concurrent load is still written.
  - A buffer head not displaced by a load is not written.
- conflictCount increments when loadValid && aluValid && aluReady && !flush, and saturates at 16'hFFFF. It is cleared only by reset.
- Grant states per cycle are: LOAD, BUF, ALU, IDLE. No multi-cycle FSM beyond the buffer occupancy.

## Timing
- Outputs regWrite, writeReg, writeData and memToReg are registered. A beat granted in cycle n appears on the write port in cycle n+1.
- Latency through the buffer is 1 + number of cycles waited.
- IDLE cycle outputs:
  - regWrite=0 and memToReg=0.
  - writeReg and writeData hold their last values.
- Reset (rstN low, asynchronous):
  - regWrite=0, writeReg=0, writeData=0, memToReg=0.
  - pending=0, pointers=0, conflictCount=0.
  - aluReady=1 by derivation.
  - Inputs are ignored while rstN is low.
- Reset mid-operation discards all buffered entries. The first write after release comes from inputs sampled at or after the first rising edge with rstN high.
- When the buffer is full (pending=DEPTH), aluReady=0. A load in that cycle still writes and does not change pending. With no load, the head drains and aluReady returns to 1 the next cycle.

## Test plan
- **ALU only:** aluValid=1, aluDest=3, aluResult=32'h1234 with no load -> next cycle regWrite=1, writeReg=3, writeData=32'h1234, memToReg=0; pending stays 0.
- **Collision:** load (dest 4, readData=32'hAAAA) and ALU (dest 5, 32'h5555) in the same cycle.
  - Cycle +1: write r4=AAAA with memToReg=1; pending=1; conflictCount=1.
  - Cycle +2: write r5=5555 with memToReg=0.
- **Full buffer, DEPTH=2:** loads every cycle for 4 cycles while ALU presents continuously.
  - pending reaches 2 and aluReady falls to 0.
  - After the loads stop, the two ALU results are written in acceptance order and aluReady returns to 1.
- **Register 0:** ALU beat with aluDest=0 -> regWrite=0 in the slot; a following beat to r7 is written one cycle later with no gap lost.
- **Flush:** with pending=2, assert flush together with a load to r9.
  - Next cycle: r9 is written and pending=0.
  - The two buffered ALU entries are never written.
- **Reset mid-operation:** rstN pulsed low with pending=2 -> outputs go to 0 immediately, pending=0, conflictCount=0, aluReady=1; no stale writes after release.
